// File: rtl/jts16_sdram_bridge.sv
// Single-port bridge between the System 16 main-CPU bus decoder and the SDRAM controller.
// Serialises ROM, work-RAM and VRAM accesses; a one-word ROM hit register short-circuits repeated fetches.
module jts16_sdram_bridge #(
    parameter logic [21:0] ROM_OFFSET  = 22'h00_0000,
    parameter logic [21:0] RAM_OFFSET  = 22'h10_0000,
    parameter logic [21:0] VRAM_OFFSET = 22'h10_2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rom_cs,
    input  logic [16:0] rom_addr,
    input  logic        ram_cs,
    input  logic        vram_cs,
    input  logic [12:0] ram_addr,
    input  logic        UDSWn,
    input  logic        LDSWn,
    input  logic [15:0] cpu_dout,
    output logic [15:0] rom_data,
    output logic        rom_ok,
    output logic [15:0] ram_data,
    output logic        ram_ok,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    output logic        sdram_we,
    output logic [1:0]  sdram_dsn,
    output logic [15:0] sdram_din,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    input  logic [15:0] sdram_dout
);

    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
    localparam logic [1:0] SRC_ROM = 2'd0, SRC_RAM = 2'd1, SRC_VRAM = 2'd2;

    logic [1:0]  st;
    logic [1:0]  src;
    logic [16:0] lat_rom_addr;
    logic [12:0] lat_ram_addr;
    logic [15:0] rd_buf;
    logic        hit_valid;
    logic [16:0] hit_tag;
    logic [15:0] hit_data;

    logic rom_hit, any_ok, src_cs, rom_keep, ram_keep, ram_wr;

    // An ok stays valid only while its requester still presents the latched address.
    always_comb begin
        rom_hit  = hit_valid && (hit_tag == rom_addr);
        any_ok   = rom_ok | ram_ok;
        src_cs   = (src == SRC_VRAM) ? vram_cs : ram_cs;
        rom_keep = rom_cs && (rom_addr == lat_rom_addr);
        ram_keep = src_cs && (ram_addr == lat_ram_addr);
        ram_wr   = ~(UDSWn & LDSWn);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= IDLE;
            src          <= SRC_ROM;
            lat_rom_addr <= '0;
            lat_ram_addr <= '0;
            rd_buf       <= '0;
            rom_data     <= '0;
            rom_ok       <= 1'b0;
            ram_data     <= '0;
            ram_ok       <= 1'b0;
            sdram_req    <= 1'b0;
            sdram_addr   <= '0;
            sdram_we     <= 1'b0;
            sdram_dsn    <= 2'b11;
            sdram_din    <= '0;
            // NOTE: only hit_valid gates the cache; tag/data are cleared just to keep reset state deterministic.
            hit_valid    <= 1'b0;
            hit_tag      <= '0;
            hit_data     <= '0;
        end else begin
            if (rom_ok && !rom_keep) rom_ok <= 1'b0;
            if (ram_ok && !ram_keep) ram_ok <= 1'b0;
            case (st)
                IDLE: if (!any_ok) begin
                    if (ram_cs || vram_cs) begin
                        src          <= ram_cs ? SRC_RAM : SRC_VRAM;
                        lat_ram_addr <= ram_addr;
                        sdram_addr   <= (ram_cs ? RAM_OFFSET : VRAM_OFFSET) + {9'd0, ram_addr};
                        sdram_we     <= ram_wr;
                        sdram_dsn    <= ram_wr ? {UDSWn, LDSWn} : 2'b00;
                        sdram_din    <= cpu_dout;
                        sdram_req    <= 1'b1;
                        st           <= REQ;
                    end else if (rom_cs) begin
                        src          <= SRC_ROM;
                        lat_rom_addr <= rom_addr;
                        if (rom_hit) begin
                            rom_data <= hit_data;
                            rom_ok   <= 1'b1;
                        end else begin
                            sdram_addr <= ROM_OFFSET + {5'd0, rom_addr};
                            sdram_we   <= 1'b0;
                            sdram_dsn  <= 2'b00;
                            sdram_din  <= cpu_dout;
                            sdram_req  <= 1'b1;
                            st         <= REQ;
                        end
                    end
                end
                REQ: if (sdram_ack) begin
                    sdram_req <= 1'b0;
                    st        <= WAIT;
                end
                WAIT: if (sdram_rdy) begin
                    rd_buf <= sdram_dout;
                    if (src == SRC_ROM) begin
                        hit_valid <= 1'b1;
                        hit_tag   <= lat_rom_addr;
                        hit_data  <= sdram_dout;
                    end
                    st <= DONE;
                end
                DONE: begin
                    // Results for a requester that moved on are dropped; the hit register was already updated.
                    if (src == SRC_ROM) begin
                        if (rom_keep) begin
                            rom_ok   <= 1'b1;
                            rom_data <= rd_buf;
                        end
                    end else if (ram_keep) begin
                        ram_ok <= 1'b1;
                        if (!sdram_we) ram_data <= rd_buf;
                    end
                    st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
